pool2x2_window: RTL and testbench
=================================

// Module: pool2x2_window
// PURPOSE
//   Streaming window gatherer for 2x2 stride-2 max pooling. Accepts signed 8-bit
//   conv results one per beat in raster order (row 0 left->right, then row 1, ...),
//   buffers one image row and presents each complete non-overlapping 2x2 window as
//   conv0..conv3 to the downstream 4-input max unit. Sits between conv engine and pool.
// PARAMETERS
//   DW     8  data width of each conv result (signed)
//   IMG_W  8  feature-map width in pixels; even, >= 2
//   IMG_H  8  feature-map height in rows; even, >= 2
// PORTS
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   clr        in   1   synchronous frame restart: drop partial frame, counters to 0
//   in_valid   in   1   in_data valid
//   in_ready   out  1   block accepts in_data this cycle
//   in_data    in   DW  signed conv result, raster order
//   out_valid  out  1   conv0..conv3 hold a complete window
//   out_ready  in   1   downstream consumes the window this cycle
//   conv0      out  DW  top-left     (row 2r,   col 2c)
//   conv1      out  DW  top-right    (row 2r,   col 2c+1)
//   conv2      out  DW  bottom-left  (row 2r+1, col 2c)
//   conv3      out  DW  bottom-right (row 2r+1, col 2c+1)
//   frame_done out  1   one-cycle pulse when the last window of a frame is accepted
// BEHAVIOUR
// - Reset (rst_n=0, async): out_valid=0, conv0..conv3=0, frame_done=0, col/row
//   counters=0, held pixel=0. The row buffer is not cleared and is never read before
//   it is rewritten.
// - Accept: input beat fires when in_valid && in_ready.
//   in_ready = !out_valid || out_ready (one output register, no skid buffer).
// - Counters: col 0..IMG_W-1 and row 0..IMG_H-1, advanced per accepted beat.
//   col wraps to 0 and row increments. After (IMG_W-1, IMG_H-1), both wrap to 0.
// - Even row: accepted pixel is written to rowbuf[col]. No output.
// - Odd row, even col: pixel is latched into the held register. No output.
// - Odd row, odd col: the window completes on that beat. Next cycle:
//   out_valid=1, conv0=rowbuf[col-1], conv1=rowbuf[col], conv2=held, conv3=in_data.
//   Latency is 1 cycle from the completing beat to out_valid.
// - Output hold: out_valid and conv* stay stable until out_valid && out_ready.
//   - Consume with no new window in the same cycle: out_valid drops next cycle.
//   - Consume while a completing beat is accepted in the same cycle: the register
//     reloads and out_valid stays 1 (back-to-back throughput).
// - frame_done: asserted for one cycle when the window from (row IMG_H-1,
//   col IMG_W-1) is consumed (out_valid && out_ready).
// - Signed data passes through unmodified. No arithmetic, no saturation.
// - clr=1 (synchronous): same effect as reset on out_valid, counters, held register
//   and frame_done. in_ready=1 during clr and no input is accepted that cycle.
//   clr takes priority over a simultaneous input beat or output consume.
// - Reset or clr mid-frame: the partial frame is discarded. The next accepted beat
//   is treated as pixel (0,0).
// - in_valid=0 gaps are allowed anywhere: no state changes, output held.
// - Windows total IMG_W/2 * IMG_H/2 per frame, in raster window order.
// TESTING
// 1. IMG_W=4, IMG_H=4, pixels 0..15 streamed, out_ready=1 -> 4 windows
//    {0,1,4,5}, {2,3,6,7}, {8,9,12,13}, {10,11,14,15}; frame_done after the 4th.
// 2. Signed data: row0 = -128, 127, -1, 0; row1 = 5, -5, -128, 127 ->
//    {-128,127,5,-5} and {-1,0,-128,127}, exact bit patterns preserved.
// 3. out_ready=0 held 5 cycles while a window is pending -> in_ready=0,
//    conv* stable; release -> the next window follows with no data lost.
// 4. Random in_valid gaps plus random out_ready over 3 frames, compared against a
//    reference model -> identical window sequence; exactly 3 frame_done pulses.
// 5. rst_n pulse after 6 pixels, then a fresh frame 100..115 -> windows contain
//    only 100..115 values, first is {100,101,104,105}.
// 6. clr asserted on the same cycle as a completing beat -> no window emitted;
//    the next 16 beats form a clean frame.

Source files
------------

// File: rtl/pool2x2_window.sv
// rtl/pool2x2_window.sv - 2x2 stride-2 pooling window gatherer with one-row line buffer
module pool2x2_window #(
    parameter int DW    = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] conv0,
    output logic [DW-1:0] conv1,
    output logic [DW-1:0] conv2,
    output logic [DW-1:0] conv3,
    output logic          frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [DW-1:0] held;
    logic [DW-1:0] rowbuf [IMG_W];
    logic          out_last;

    logic          accept;
    logic          consume;
    logic          complete;
    logic          col_last;
    logic          row_last;
    logic [CW-1:0] col_left;

    // Single output register: a new beat is taken whenever that register is free or draining.
    // clr forces ready high but the beat is discarded.
    assign in_ready = clr | ~out_valid | out_ready;
    assign accept   = in_valid & in_ready & ~clr;
    assign consume  = out_valid & out_ready;
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    // Window completes on an odd column, so its left partner is the column with bit 0 cleared.
    assign complete = accept & row[0] & col[0];
    assign col_left = col ^ CW'(1);

    // Raster position counters, restarted by reset or clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Even rows fill the line buffer; it is always rewritten before being read.
    always_ff @(posedge clk) begin
        if (accept && !row[0]) begin
            rowbuf[col] <= in_data;
        end
    end

    // Bottom-left pixel of the current window, held until its right neighbour arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held <= '0;
        end else if (clr) begin
            held <= '0;
        end else if (accept && row[0] && !col[0]) begin
            held <= in_data;
        end
    end

    // Output window register: loads on a completing beat, empties on consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            conv0     <= '0;
            conv1     <= '0;
            conv2     <= '0;
            conv3     <= '0;
        end else if (clr) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (complete) begin
            out_valid <= 1'b1;
            out_last  <= row_last & col_last;
            conv0     <= rowbuf[col_left];
            conv1     <= rowbuf[col];
            conv2     <= held;
            conv3     <= in_data;
        end else if (consume) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    // One-cycle pulse after the final window of a frame leaves the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else if (clr) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= consume & out_last;
        end
    end

endmodule

// File: tb/tb_pool2x2_window.sv
// tb/tb_pool2x2_window.sv - randomized self-checking bench for pool2x2_window
module tb_pool2x2_window;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] conv0, conv1, conv2, conv3;
    logic       frame_done;

    int n_chk  = 0;
    int n_pass = 0;
    int fd_cnt = 0;
    int win_idx = 0;
    logic fd_exp = 1'b0;
    logic s_done;
    logic [31:0] hold_win;

    logic [7:0]  stim[$];
    logic [31:0] got[$];
    logic [31:0] exp_q[$];

    pool2x2_window #(.DW(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .conv0      (conv0),
        .conv1      (conv1),
        .conv2      (conv2),
        .conv3      (conv3),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_chk++;
        if (obs === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, req);
    endtask

    // Observe consumed windows and the frame_done pulse that must follow a frame's last one.
    always @(negedge clk) begin
        if (!rst_n) fd_exp = 1'b0;
        if (fd_exp || frame_done) check("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
        if (frame_done) fd_cnt++;
        fd_exp = 1'b0;
        if (!rst_n || clr) begin
            win_idx = 0;
        end else if (out_valid && out_ready) begin
            got.push_back({conv0, conv1, conv2, conv3});
            if (win_idx == (W / 2) * (H / 2) - 1) begin
                fd_exp  = 1'b1;
                win_idx = 0;
            end else begin
                win_idx++;
            end
        end
    end

    // Reference: cut each whole frame in stim into its non-overlapping 2x2 windows.
    task automatic model();
        for (int f = 0; f < stim.size() / N; f++)
            for (int r = 0; r < H; r += 2)
                for (int c = 0; c < W; c += 2)
                    exp_q.push_back({stim[f*N + r*W + c],     stim[f*N + r*W + c + 1],
                                     stim[f*N + (r+1)*W + c], stim[f*N + (r+1)*W + c + 1]});
    endtask

    task automatic send(input logic [7:0] d, input int gap_max);
        int gap;
        gap = $urandom_range(gap_max, 0);
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic run_stream(input int gap_max);
        for (int i = 0; i < stim.size(); i++) send(stim[i], gap_max);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) check(tag, got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_conv", {conv0, conv1, conv2, conv3}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Ascending pixels, no back-pressure.
        out_ready = 1'b1; fd_cnt = 0;
        stim.delete();
        for (int i = 0; i < N; i++) stim.push_back(8'(i));
        model();
        run_stream(0);
        drain();
        check("seq_first", got[0], 32'h00010405);
        check("seq_last", got[3], 32'h0a0b0e0f);
        compare("seq_win");
        check("seq_fd_cnt", fd_cnt, 1);

        // Signed extremes pass through untouched.
        stim.delete();
        stim = '{8'h80, 8'h7f, 8'hff, 8'h00, 8'h05, 8'hfb, 8'h80, 8'h7f};
        for (int i = 8; i < N; i++) stim.push_back(8'($urandom));
        model();
        run_stream(1);
        drain();
        check("signed_w0", got[0], 32'h807f05fb);
        check("signed_w1", got[1], 32'hff00807f);
        compare("signed_win");

        // Back-pressure: hold the first window for five cycles.
        stim.delete();
        for (int i = 0; i < N; i++) stim.push_back(8'(50 + i));
        model();
        out_ready = 1'b0;
        fork
            run_stream(0);
            begin
                for (int k = 0; k < 100 && !out_valid; k++) @(negedge clk);
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                hold_win = {conv0, conv1, conv2, conv3};
                repeat (5) begin
                    @(negedge clk);
                    check("hold_in_ready", {31'd0, in_ready}, 32'd0);
                    check("hold_conv", {conv0, conv1, conv2, conv3}, hold_win);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();
        compare("hold_win");

        // Three frames with random input gaps and random consumer stalls.
        fd_cnt = 0; s_done = 1'b0;
        stim.delete();
        for (int i = 0; i < 3 * N; i++) stim.push_back(8'($urandom));
        model();
        fork
            begin run_stream(3); s_done = 1'b1; end
            while (!s_done) begin
                @(posedge clk); #1 out_ready = 1'($urandom_range(1, 0));
            end
        join
        drain();
        compare("rand_win");
        check("rand_fd_cnt", fd_cnt, 3);

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 6; i++) send(8'(i), 0);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        got.delete();
        stim.delete();
        for (int i = 0; i < N; i++) stim.push_back(8'(100 + i));
        model();
        run_stream(1);
        drain();
        check("rst_first", got[0], 32'h64656869);
        compare("rst_win");

        // clr on a completing beat: beat dropped, window suppressed.
        for (int i = 0; i < 5; i++) send(8'(i), 0);
        in_valid = 1'b1; in_data = 8'd5; clr = 1'b1;
        @(negedge clk);
        check("clr_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1 clr = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("clr_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        got.delete();
        stim.delete();
        for (int i = 0; i < N; i++) stim.push_back(8'(200 + i));
        model();
        run_stream(0);
        drain();
        compare("clr_win");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
